// File: rtl/servo_pkg.sv
// Shared servo definitions: angle range/width, sequencer states and per-axis helpers.
// Also consumed by the pwm_servos angle-to-pulse mapping.
package servo_pkg;

    localparam int ANGLE_W   = 11;
    localparam int DIFF_W    = ANGLE_W + 1;
    localparam int COORD_MIN = -270;
    localparam int COORD_MAX = 270;

    typedef logic signed [ANGLE_W-1:0] angle_t;
    typedef logic signed [DIFF_W-1:0]  diff_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        SETTLE = 2'd2
    } state_e;

    function automatic angle_t clamp_angle(input angle_t a);
        angle_t r;
        r = a;
        if (a > angle_t'(COORD_MAX)) r = angle_t'(COORD_MAX);
        if (a < angle_t'(COORD_MIN)) r = angle_t'(COORD_MIN);
        return r;
    endfunction

    // One bounded step of cur toward tgt; the difference needs one extra bit to avoid overflow.
    function automatic angle_t step_axis(input angle_t cur, input angle_t tgt, input int step_deg);
        diff_t  d;
        diff_t  mag;
        angle_t r;
        d   = {tgt[ANGLE_W-1], tgt} - {cur[ANGLE_W-1], cur};
        mag = d[DIFF_W-1] ? -d : d;
        if (mag <= diff_t'(step_deg)) r = tgt;
        else if (d[DIFF_W-1])         r = cur - angle_t'(step_deg);
        else                          r = cur + angle_t'(step_deg);
        return r;
    endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Free-running frame counter; tick is high for one cycle each time the count wraps to 0.
module servo_tick_gen #(
    parameter int PERIOD = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          wrap;

    always_comb begin
        wrap   = (cnt_q == CW'(PERIOD - 1));
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        tick_d = wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/servo_motion_ctrl.sv
// Three-axis motion sequencer: captures clamped targets, slews x/y/z one bounded step per
// PWM frame tick, holds for a settle time, then pulses done.
module servo_motion_ctrl
    import servo_pkg::*;
#(
    parameter int FREQ         = 25_000_000,
    parameter int TARGET_FREQ  = 10,
    parameter int STEP_DEG     = 5,
    parameter int SETTLE_TICKS = 3,
    parameter int HOME_DEG     = 90
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ANGLE_W-1:0] cmd_x,
    input  logic [ANGLE_W-1:0] cmd_y,
    input  logic [ANGLE_W-1:0] cmd_z,
    output logic [ANGLE_W-1:0] x,
    output logic [ANGLE_W-1:0] y,
    output logic [ANGLE_W-1:0] z,
    output logic               busy,
    output logic               done
);

    localparam int     PERIOD    = FREQ / TARGET_FREQ;
    localparam int     SW        = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;
    localparam bit     NO_SETTLE = (SETTLE_TICKS == 0);
    localparam angle_t HOME      = angle_t'(HOME_DEG);

    state_e        state_q, state_d;
    angle_t        x_q, x_d, y_q, y_d, z_q, z_d;
    angle_t        tx_q, tx_d, ty_q, ty_d, tz_q, tz_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          done_q, done_d;
    logic          tick;
    logic          at_target;

    servo_tick_gen #(.PERIOD(PERIOD)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Handshake: a command transfers on a rising edge with cmd_valid && cmd_ready. cmd_ready is
    // high only in IDLE, so commands offered while busy stay pending at the source until IDLE.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        tx_d      = tx_q;
        ty_d      = ty_q;
        tz_d      = tz_q;
        settle_d  = settle_q;
        done_d    = 1'b0;
        at_target = (x_q == tx_q) && (y_q == ty_q) && (z_q == tz_q);

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    tx_d    = clamp_angle(angle_t'(cmd_x));
                    ty_d    = clamp_angle(angle_t'(cmd_y));
                    tz_d    = clamp_angle(angle_t'(cmd_z));
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (at_target) begin
                    if (NO_SETTLE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = SETTLE;
                        settle_d = SW'(SETTLE_TICKS);
                    end
                end else if (tick) begin
                    x_d = step_axis(x_q, tx_q, STEP_DEG);
                    y_d = step_axis(y_q, ty_q, STEP_DEG);
                    z_d = step_axis(z_q, tz_q, STEP_DEG);
                end
            end
            SETTLE: begin
                if (tick) begin
                    settle_d = settle_q - SW'(1);
                    if (settle_q == SW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= HOME;
            y_q      <= HOME;
            z_q      <= HOME;
            tx_q     <= HOME;
            ty_q     <= HOME;
            tz_q     <= HOME;
            settle_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            tz_q     <= tz_d;
            settle_q <= settle_d;
            done_q   <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign x         = x_q;
    assign y         = y_q;
    assign z         = z_q;

endmodule

// File: tb/tb_servo_motion_ctrl.sv
// Scoreboard bench for servo_motion_ctrl: expected x/y/z step sequences are queued on command
// acceptance and popped as the outputs change; done timing is checked against the tick period.
module tb_servo_motion_ctrl;

    localparam int STEP   = 5;
    localparam int SETTLE = 3;
    localparam int TPER   = 10;
    localparam int HOME   = 90;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [10:0] cmd_x = '0;
    logic [10:0] cmd_y = '0;
    logic [10:0] cmd_z = '0;
    logic        cmd_ready;
    logic [10:0] x, y, z;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    servo_motion_ctrl #(
        .FREQ         (100),
        .TARGET_FREQ  (10),
        .STEP_DEG     (STEP),
        .SETTLE_TICKS (SETTLE),
        .HOME_DEG     (HOME)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_z     (cmd_z),
        .x         (x),
        .y         (y),
        .z         (z),
        .busy      (busy),
        .done      (done)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [32:0] exp_q[$];
    int          mx = HOME, my = HOME, mz = HOME;
    logic [32:0] prev_xyz;
    int          last_chg = 0;
    int          accept_cyc = 0;
    bit          first_pending = 1'b0;

    function automatic logic [32:0] pack3(input int a, input int b, input int c);
        logic [10:0] pa, pb, pc;
        pa = 11'(a);
        pb = 11'(b);
        pc = 11'(c);
        return {pa, pb, pc};
    endfunction

    function automatic int clampv(input int v);
        if (v > 270)  return 270;
        if (v < -270) return -270;
        return v;
    endfunction

    function automatic int approach(input int c, input int t);
        if (t > c) return (t - c > STEP) ? c + STEP : t;
        if (t < c) return (c - t > STEP) ? c - STEP : t;
        return c;
    endfunction

    // Clock/cycle bookkeeping
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Output monitor: every x/y/z change must match the head of the expected queue
    initial begin
        prev_xyz = pack3(HOME, HOME, HOME);
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_xyz = pack3(HOME, HOME, HOME);
            end else if ({x, y, z} !== prev_xyz) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_move: got xyz=%h, required no change from %h", {x, y, z}, prev_xyz);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    if ({x, y, z} !== e) begin
                        miscompares++;
                        $display("FAIL step_value: got xyz=%h, required %h", {x, y, z}, e);
                    end
                end
                vectors++;
                if (first_pending) begin
                    if (cyc - accept_cyc < 2 || cyc - accept_cyc > TPER + 1) begin
                        miscompares++;
                        $display("FAIL first_step_latency: got %0d cycles, required 2..%0d", cyc - accept_cyc, TPER + 1);
                    end
                    first_pending = 1'b0;
                end else if (cyc - last_chg != TPER) begin
                    miscompares++;
                    $display("FAIL step_spacing: got %0d cycles, required %0d", cyc - last_chg, TPER);
                end
                last_chg = cyc;
                prev_xyz = {x, y, z};
            end
        end
    end

    // Model the slew from the current model position and queue every expected output change
    task automatic push_moves(input int tx, input int ty, input int tz, output int steps);
        steps = 0;
        while (mx != tx || my != ty || mz != tz) begin
            mx = approach(mx, tx);
            my = approach(my, ty);
            mz = approach(mz, tz);
            exp_q.push_back(pack3(mx, my, mz));
            steps++;
        end
    endtask

    task automatic send_cmd(input int cx, input int cy, input int cz, output int steps);
        int n;
        steps = 0;
        @(negedge clk);
        cmd_x = 11'(cx);
        cmd_y = 11'(cy);
        cmd_z = 11'(cz);
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!cmd_ready) begin
            miscompares++;
            $display("FAIL accept_timeout: got cmd_ready=%b, required 1", cmd_ready);
        end else begin
            push_moves(clampv(cx), clampv(cy), clampv(cz), steps);
            accept_cyc = cyc;
            first_pending = (steps > 0);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic check_busy_after_accept();
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_after_accept: got busy=%b cmd_ready=%b, required 1/0", busy, cmd_ready);
        end
    endtask

    task automatic wait_done(input int steps, output int done_cyc);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        done_cyc = cyc;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_timeout: got done=%b, required 1", done);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL steps_missing: got %0d pending, required 0", exp_q.size());
        end
        vectors++;
        if ({x, y, z} !== pack3(mx, my, mz)) begin
            miscompares++;
            $display("FAIL final_position: got xyz=%h, required %h", {x, y, z}, pack3(mx, my, mz));
        end
        if (steps > 0) begin
            vectors++;
            if (done_cyc - last_chg != SETTLE * TPER) begin
                miscompares++;
                $display("FAIL settle_time: got %0d cycles, required %0d", done_cyc - last_chg, SETTLE * TPER);
            end
        end
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_at_done: got cmd_ready=%b busy=%b, required 1/0", cmd_ready, busy);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_width: got done=%b, required 0", done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({x, y, z} !== pack3(HOME, HOME, HOME)) begin
            miscompares++;
            $display("FAIL reset_xyz: got %h, required %h", {x, y, z}, pack3(HOME, HOME, HOME));
        end
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got ready=%b busy=%b done=%b, required 1/0/0", cmd_ready, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({x, y, z} !== pack3(HOME, HOME, HOME) || cmd_ready !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got xyz=%h ready=%b done=%b, required %h/1/0", {x, y, z}, cmd_ready, done, pack3(HOME, HOME, HOME));
        end
    endtask

    task automatic test_no_move();
        int steps, dc;
        send_cmd(90, 90, 90, steps);
        check_busy_after_accept();
        wait_done(steps, dc);
        vectors++;
        if (dc - accept_cyc < 2 * TPER + 3 || dc - accept_cyc > 3 * TPER + 2) begin
            miscompares++;
            $display("FAIL no_move_done_time: got %0d cycles, required %0d..%0d", dc - accept_cyc, 2 * TPER + 3, 3 * TPER + 2);
        end
    endtask

    task automatic test_small_move();
        int steps, dc;
        send_cmd(100, 80, 90, steps);
        check_busy_after_accept();
        wait_done(steps, dc);
    endtask

    task automatic test_back_to_back();
        int steps, dc, n, early;
        send_cmd(120, 60, 90, steps);
        cmd_x = 11'(90);
        cmd_y = 11'(90);
        cmd_z = 11'(90);
        cmd_valid = 1'b1;
        n = 0;
        early = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 2000) begin
            if (cmd_ready) early++;
            @(negedge clk);
            n++;
        end
        vectors++;
        if (early != 0) begin
            miscompares++;
            $display("FAIL held_off_ready: got %0d ready cycles while busy, required 0", early);
        end
        vectors++;
        if (done !== 1'b1 || cmd_ready !== 1'b1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL first_cmd_done: got done=%b ready=%b pending=%0d, required 1/1/0", done, cmd_ready, exp_q.size());
        end
        push_moves(90, 90, 90, steps);
        accept_cyc = cyc;
        first_pending = (steps > 0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check_busy_after_accept();
        wait_done(steps, dc);
    endtask

    task automatic test_clamp();
        int steps, dc;
        send_cmd(300, -400, 92, steps);
        check_busy_after_accept();
        wait_done(steps, dc);
    endtask

    task automatic test_reset_mid_move();
        int steps, n, spurious;
        send_cmd(90, 90, 90, steps);
        n = 0;
        while (x !== 11'(150) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (x !== 11'(150)) begin
            miscompares++;
            $display("FAIL reach_150: got x=%0d, required 150", $signed(x));
        end
        #2 rst = 1'b1;
        exp_q.delete();
        mx = HOME;
        my = HOME;
        mz = HOME;
        first_pending = 1'b0;
        #1;
        vectors++;
        if ({x, y, z} !== pack3(HOME, HOME, HOME) || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got xyz=%h busy=%b, required %h/0", {x, y, z}, busy, pack3(HOME, HOME, HOME));
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        repeat (4 * TPER) begin
            @(negedge clk);
            if (done) spurious++;
        end
        vectors++;
        if (spurious != 0) begin
            miscompares++;
            $display("FAIL spurious_done: got %0d pulses, required 0", spurious);
        end
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || {x, y, z} !== pack3(HOME, HOME, HOME)) begin
            miscompares++;
            $display("FAIL idle_after_reset: got ready=%b busy=%b xyz=%h, required 1/0/%h", cmd_ready, busy, {x, y, z}, pack3(HOME, HOME, HOME));
        end
    endtask

    initial begin
        test_reset();
        test_no_move();
        test_small_move();
        test_back_to_back();
        test_clamp();
        test_reset_mid_move();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
